i2c_slv_tx_arb: RTL and testbench
=================================

# i2c_slv_tx_arb

Round-robin arbiter that shares the single-byte I2C slave's transmit-data register among NUM_REQ on-chip requesters. It sits between the requesters and the slave's parallel data interface. It latches one requester's byte into the slave only while no bus transaction is active, and holds that byte until an I2C master reads it or a hold timeout expires. It then reports completion to the owning requester. Bytes written by the master are forwarded back as a one-cycle strobe.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, 2, requester ID width, must equal clog2(NUM_REQ)
- EMPTY_BYTE, 8'hFF, byte presented to slave when nothing is held
- HOLD_TO_CLKS, 4096, idle clocks a held byte may wait before being discarded
- WIDTH_HOLD_TO, 13, hold-timeout counter width, must hold HOLD_TO_CLKS
- i_clk  in  1  system clock; sole clock
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  NUM_REQ  per-requester byte pending
- i_req_data  in  8*NUM_REQ  per-requester byte; requester n uses bits [8n+7:8n]
- o_req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
- i_slv_busy  in  1  slave address-matched transaction in progress
- i_slv_rd_done  in  1  one-cycle pulse: master clocked out the held byte
- i_slv_wr_done  in  1  one-cycle pulse: master wrote a byte
- i_slv_data  in  8  slave receive byte (its o_data)
- o_slv_data  out  8  byte to slave transmit input (its i_data)
- o_tx_done  out  1  one-cycle pulse: held byte was read
- o_tx_timeout  out  1  one-cycle pulse: held byte discarded
- o_tx_id  out  ID_W  owner of current/last held byte
- o_rx_valid  out  1  one-cycle pulse: received byte valid
- o_rx_data  out  8  received byte

## Operation
- FSM states:
  - IDLE: o_slv_data = EMPTY_BYTE. Go to ARB when any i_req_valid is high and i_slv_busy is low.
  - ARB: one cycle.
    - Pick the winner starting at rr_ptr and searching upward with wrap.
    - Latch its byte into hold_reg and its index into o_tx_id.
    - Assert o_req_ready[winner] for this cycle only. Go to HOLD.
  - HOLD: o_slv_data = hold_reg.
    - On i_slv_rd_done: pulse o_tx_done next cycle, set rr_ptr = winner+1 (mod NUM_REQ), go to IDLE.
    - On timeout: pulse o_tx_timeout next cycle, set rr_ptr = winner+1, go to IDLE.
- Requester contract:
  - A requester keeps i_req_valid and its data stable until it sees its ready pulse.
  - A requester that drops valid before being granted is simply skipped.
- If all valids drop during the IDLE→ARB decision, ARB issues no ready pulse and returns to IDLE.
- Hold timer:
  - Loads HOLD_TO_CLKS on entry to HOLD and reloads while i_slv_busy is high.
  - Decrements while in HOLD with i_slv_busy low.
  - Timeout fires when the timer reaches 0.
- o_slv_data never changes while i_slv_busy is high. A return to IDLE during busy keeps hold_reg on the output until busy drops.
- RX path is independent of the FSM: i_slv_wr_done captures i_slv_data into o_rx_data, and o_rx_valid pulses the following cycle.

## Timing
- Reset values: state IDLE, rr_ptr 0, o_slv_data EMPTY_BYTE, o_req_ready 0, o_tx_done 0, o_tx_timeout 0, o_tx_id 0, o_rx_valid 0, o_rx_data 8'h00, timer HOLD_TO_CLKS.
- Latency:
  - Valid seen (slave not busy) → ready pulse: 2 cycles.
  - Ready pulse → o_slv_data updated: same edge as HOLD entry.
  - rd_done → o_tx_done: 1 cycle.
  - wr_done → o_rx_valid: 1 cycle.
- Simultaneous events:
  - rd_done and timeout in the same cycle: rd_done wins and only o_tx_done pulses.
  - rd_done while in IDLE or ARB is ignored.
- Back-to-back transfers: minimum 3 cycles between successive ready pulses (HOLD→IDLE→ARB).
- Reset asserted mid-HOLD: the held byte is dropped, with no done or timeout pulse.

## Configuration
- I2C_TX_ARB_FIXED_PRIO_EN:
  - Defined: arbitration is fixed priority, with the lowest index winning, and rr_ptr is unused.
  - Undefined: round-robin as described under Operation.

## Test plan
- Single request: req 2 valid with 8'hA5, slave idle → o_req_ready = 4'b0100 at cycle 2, o_slv_data = 8'hA5; rd_done → o_tx_done with o_tx_id = 2, then o_slv_data = 8'hFF.
- Fairness: reqs 0, 1 and 3 valid continuously, each served once → grant order 0, 1, 3, 0; with the macro defined → 0, 0, 0.
- Busy gating: i_slv_busy high while req 1 is valid → no ready pulse until busy falls, then ready 2 cycles later.
- Timeout: HOLD_TO_CLKS = 16, no rd_done, busy low → o_tx_timeout exactly 17 cycles after HOLD entry, rr_ptr advanced; a 5-cycle busy burst mid-hold delays timeout by 5 + reload.
- Simultaneous: rd_done on the timeout cycle → o_tx_done only; wr_done with i_slv_data = 8'h3C during HOLD → o_rx_valid with 8'h3C and FSM unaffected.
- Reset mid-HOLD → all outputs at reset values next cycle; a subsequent request proceeds normally.

Source files
------------

// File: rtl/i2c_slv_tx_arb_if.sv
// Requester, slave-data and completion signals of i2c_slv_tx_arb.
// The arbiter takes the slave modport; the requesters and the I2C slave core drive the master side.
interface i2c_slv_tx_arb_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
);
   logic [NUM_REQ-1:0]   i_req_valid;
   logic [8*NUM_REQ-1:0] i_req_data;
   logic [NUM_REQ-1:0]   o_req_ready;
   logic                 i_slv_busy;
   logic                 i_slv_rd_done;
   logic                 i_slv_wr_done;
   logic [7:0]           i_slv_data;
   logic [7:0]           o_slv_data;
   logic                 o_tx_done;
   logic                 o_tx_timeout;
   logic [ID_W-1:0]      o_tx_id;
   logic                 o_rx_valid;
   logic [7:0]           o_rx_data;

   modport slave (
      input  i_req_valid, i_req_data, i_slv_busy, i_slv_rd_done, i_slv_wr_done, i_slv_data,
      output o_req_ready, o_slv_data, o_tx_done, o_tx_timeout, o_tx_id, o_rx_valid, o_rx_data
   );

   modport master (
      output i_req_valid, i_req_data, i_slv_busy, i_slv_rd_done, i_slv_wr_done, i_slv_data,
      input  o_req_ready, o_slv_data, o_tx_done, o_tx_timeout, o_tx_id, o_rx_valid, o_rx_data
   );
endinterface

// File: rtl/i2c_slv_tx_arb.sv
// Shares the I2C slave's single transmit byte among NUM_REQ requesters; valid->ready 2 cycles, byte held until read or timeout.
// Requesters hold valid until their one-cycle ready pulse; define I2C_TX_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module i2c_slv_tx_arb #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned ID_W          = 2,
   parameter logic [7:0]  EMPTY_BYTE    = 8'hFF,
   parameter int unsigned HOLD_TO_CLKS  = 4096,
   parameter int unsigned WIDTH_HOLD_TO = 13
) (
   input logic             i_clk,
   input logic             i_rst,
   i2c_slv_tx_arb_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARB  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [WIDTH_HOLD_TO-1:0] TO_LOAD = WIDTH_HOLD_TO'(HOLD_TO_CLKS);

   logic [1:0]               state_q, state_d;
   logic [7:0]               slv_data_q, slv_data_d;
   logic [NUM_REQ-1:0]       ready_q, ready_d;
   logic [ID_W-1:0]          tx_id_q, tx_id_d;
   logic [WIDTH_HOLD_TO-1:0] timer_q, timer_d;
   logic                     done_q, done_d;
   logic                     timeout_q, timeout_d;
   logic                     rx_valid_q;
   logic [7:0]               rx_data_q;
`ifndef I2C_TX_ARB_FIXED_PRIO_EN
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
   logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
`endif

   logic                     grant_found;
   logic [ID_W-1:0]          grant_idx;
   logic [7:0]               grant_byte;
   logic                     any_valid;
   logic                     timeout_hit;

   assign any_valid   = |bus.i_req_valid;
   assign timeout_hit = (state_q == ST_HOLD) && !bus.i_slv_busy && (timer_q == '0);

   // First pending requester at or above the search start, wrapping past NUM_REQ-1.
   always_comb begin
      logic [ID_W:0] cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef I2C_TX_ARB_FIXED_PRIO_EN
         cand = (ID_W+1)'(i);
`else
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
`endif
         if (!grant_found && bus.i_req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   assign grant_byte = bus.i_req_data[8*grant_idx +: 8];

   always_comb begin
      state_d    = state_q;
      slv_data_d = slv_data_q;
      ready_d    = '0;
      tx_id_d    = tx_id_q;
      timer_d    = timer_q;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
`ifndef I2C_TX_ARB_FIXED_PRIO_EN
      rr_ptr_d   = rr_ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!bus.i_slv_busy) slv_data_d = EMPTY_BYTE;
            if (any_valid && !bus.i_slv_busy) state_d = ST_ARB;
         end
         ST_ARB: begin
            state_d = ST_IDLE;
            // A transaction starting in this cycle would see the output change mid-byte, so skip the grant.
            if (grant_found && !bus.i_slv_busy) begin
               state_d    = ST_HOLD;
               slv_data_d = grant_byte;
               tx_id_d    = grant_idx;
               timer_d    = TO_LOAD;
               for (int unsigned i = 0; i < NUM_REQ; i++) ready_d[i] = (grant_idx == ID_W'(i));
            end
         end
         ST_HOLD: begin
            if (bus.i_slv_busy)     timer_d = TO_LOAD;
            else if (timer_q != '0) timer_d = timer_q - 1'b1;
            if (bus.i_slv_rd_done || timeout_hit) begin
               state_d   = ST_IDLE;
               done_d    = bus.i_slv_rd_done;
               timeout_d = !bus.i_slv_rd_done;
               if (!bus.i_slv_busy) slv_data_d = EMPTY_BYTE;
`ifndef I2C_TX_ARB_FIXED_PRIO_EN
               rr_ptr_d  = (tx_id_q == LAST_ID) ? '0 : tx_id_q + 1'b1;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         slv_data_q <= EMPTY_BYTE;
         ready_q    <= '0;
         tx_id_q    <= '0;
         timer_q    <= TO_LOAD;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
`ifndef I2C_TX_ARB_FIXED_PRIO_EN
         rr_ptr_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         slv_data_q <= slv_data_d;
         ready_q    <= ready_d;
         tx_id_q    <= tx_id_d;
         timer_q    <= timer_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         rx_valid_q <= bus.i_slv_wr_done;
         if (bus.i_slv_wr_done) rx_data_q <= bus.i_slv_data;
`ifndef I2C_TX_ARB_FIXED_PRIO_EN
         rr_ptr_q   <= rr_ptr_d;
`endif
      end
   end

   assign bus.o_req_ready  = ready_q;
   assign bus.o_slv_data   = slv_data_q;
   assign bus.o_tx_done    = done_q;
   assign bus.o_tx_timeout = timeout_q;
   assign bus.o_tx_id      = tx_id_q;
   assign bus.o_rx_valid   = rx_valid_q;
   assign bus.o_rx_data    = rx_data_q;
endmodule

// File: tb/tb_i2c_slv_tx_arb.sv
// Scoreboard bench for i2c_slv_tx_arb: expected grants, completions and RX bytes are queued with their due cycle.
module tb_i2c_slv_tx_arb;
   localparam logic [1:0] K_DONE = 2'b10;
   localparam logic [1:0] K_TO   = 2'b01;

   typedef struct { int id; logic [7:0] data; int cyc; } grant_t;
   typedef struct { logic [1:0] kind; int id; logic [7:0] slv; int cyc; } cmpl_t;
   typedef struct { logic [7:0] data; int cyc; } rx_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   auto_drop = 1'b1;
   grant_t grant_q[$];
   cmpl_t  cmpl_q[$];
   rx_t    rx_q[$];
   int     ord[4];

   i2c_slv_tx_arb_if #(.NUM_REQ(4), .ID_W(2)) bus();

   i2c_slv_tx_arb #(
      .NUM_REQ(4), .ID_W(2), .EMPTY_BYTE(8'hFF), .HOLD_TO_CLKS(16), .WIDTH_HOLD_TO(5)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic sb_monitor();
      grant_t g;
      cmpl_t  c;
      rx_t    r;
      if (bus.o_req_ready != 4'b0) begin
         if (grant_q.size() == 0) check_eq("grant_unexpected", 32'(bus.o_req_ready), 0);
         else begin
            g = grant_q.pop_front();
            check_eq("grant_onehot", 32'(bus.o_req_ready), 1 << g.id);
            check_eq("grant_id", 32'(bus.o_tx_id), g.id);
            check_eq("grant_byte", 32'(bus.o_slv_data), 32'(g.data));
            check_eq("grant_cycle", cyc, g.cyc);
         end
      end
      if (bus.o_tx_done || bus.o_tx_timeout) begin
         if (cmpl_q.size() == 0) check_eq("cmpl_unexpected", {bus.o_tx_done, bus.o_tx_timeout}, 0);
         else begin
            c = cmpl_q.pop_front();
            check_eq("cmpl_kind", {bus.o_tx_done, bus.o_tx_timeout}, 32'(c.kind));
            check_eq("cmpl_id", 32'(bus.o_tx_id), c.id);
            check_eq("cmpl_slv_data", 32'(bus.o_slv_data), 32'(c.slv));
            check_eq("cmpl_cycle", cyc, c.cyc);
         end
      end
      if (bus.o_rx_valid) begin
         if (rx_q.size() == 0) check_eq("rx_unexpected", 32'(bus.o_rx_valid), 0);
         else begin
            r = rx_q.pop_front();
            check_eq("rx_data", 32'(bus.o_rx_data), 32'(r.data));
            check_eq("rx_cycle", cyc, r.cyc);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sb_monitor();
      if (auto_drop) bus.i_req_valid = bus.i_req_valid & ~bus.o_req_ready;
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_slv_data"}, 32'(bus.o_slv_data), 32'hFF);
      check_eq({pfx, "_ready"}, 32'(bus.o_req_ready), 0);
      check_eq({pfx, "_done"}, 32'(bus.o_tx_done), 0);
      check_eq({pfx, "_timeout"}, 32'(bus.o_tx_timeout), 0);
      check_eq({pfx, "_tx_id"}, 32'(bus.o_tx_id), 0);
      check_eq({pfx, "_rx_valid"}, 32'(bus.o_rx_valid), 0);
      check_eq({pfx, "_rx_data"}, 32'(bus.o_rx_data), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_req_valid = '0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   // Single request from idle: ready is due two cycles later.
   task automatic post(input int id, input logic [7:0] data);
      bus.i_req_data[8*id +: 8] = data;
      bus.i_req_valid[id] = 1'b1;
      grant_q.push_back('{id: id, data: data, cyc: cyc + 2});
   endtask

   task automatic read_byte(input int id);
      cmpl_q.push_back('{kind: K_DONE, id: id, slv: 8'hFF, cyc: cyc + 1});
      bus.i_slv_rd_done = 1'b1;
      tick();
      bus.i_slv_rd_done = 1'b0;
   endtask

   initial begin
      int c;
      int e;
      rst = 1'b1;
      bus.i_req_valid = '0;
      bus.i_req_data = '0;
      bus.i_slv_busy = 1'b0;
      bus.i_slv_rd_done = 1'b0;
      bus.i_slv_wr_done = 1'b0;
      bus.i_slv_data = 8'h00;

      do_reset();
      check_reset_vals("reset");

      // Single request, then a stray rd_done while idle.
      post(2, 8'hA5);
      tick(); tick();
      read_byte(2);
      tick();
      bus.i_slv_rd_done = 1'b1;
      tick();
      bus.i_slv_rd_done = 1'b0;
      repeat (3) tick();

      // Fairness with requesters 0, 1, 3 continuously pending.
      do_reset();
`ifdef I2C_TX_ARB_FIXED_PRIO_EN
      ord = '{0, 0, 0, 0};
`else
      ord = '{0, 1, 3, 0};
`endif
      auto_drop = 1'b0;
      bus.i_req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      bus.i_req_valid = 4'b1011;
      c = cyc;
      for (int k = 0; k < 4; k++) begin
         grant_q.push_back('{id: ord[k], data: 8'h10 + 8'(ord[k]), cyc: c + 2 + 3*k});
         cmpl_q.push_back('{kind: K_DONE, id: ord[k], slv: 8'hFF, cyc: c + 3 + 3*k});
      end
      tick(); tick();
      for (int k = 0; k < 4; k++) begin
         bus.i_slv_rd_done = 1'b1;
         tick();
         bus.i_slv_rd_done = 1'b0;
         if (k < 3) begin tick(); tick(); end
      end
      bus.i_req_valid = '0;
      auto_drop = 1'b1;
      repeat (3) tick();

      // Busy gating: no grant while the slave is busy.
      bus.i_slv_busy = 1'b1;
      bus.i_req_data[15:8] = 8'h5A;
      bus.i_req_valid[1] = 1'b1;
      repeat (4) tick();
      bus.i_slv_busy = 1'b0;
      grant_q.push_back('{id: 1, data: 8'h5A, cyc: cyc + 2});
      tick(); tick();
      read_byte(1);
      tick();

      // Timeout, then rr pointer must have moved past requester 3.
      post(3, 8'hC3);
      tick(); tick();
      e = cyc;
      cmpl_q.push_back('{kind: K_TO, id: 3, slv: 8'hFF, cyc: e + 17});
      repeat (17) tick();
      c = cyc;
      bus.i_req_data[7:0] = 8'h0A;
      bus.i_req_data[31:24] = 8'h3B;
      bus.i_req_valid = 4'b1001;
`ifdef I2C_TX_ARB_FIXED_PRIO_EN
      grant_q.push_back('{id: 0, data: 8'h0A, cyc: c + 2});
      grant_q.push_back('{id: 3, data: 8'h3B, cyc: c + 5});
`else
      grant_q.push_back('{id: 0, data: 8'h0A, cyc: c + 2});
      grant_q.push_back('{id: 3, data: 8'h3B, cyc: c + 5});
`endif
      tick(); tick();
      read_byte(0);
      tick(); tick();
      read_byte(3);
      tick();

      // Busy burst mid-hold reloads the timer and freezes the output byte.
      post(2, 8'h77);
      tick(); tick();
      e = cyc;
      cmpl_q.push_back('{kind: K_TO, id: 2, slv: 8'hFF, cyc: e + 26});
      repeat (4) tick();
      bus.i_slv_busy = 1'b1;
      repeat (5) tick();
      check_eq("busy_hold_byte", 32'(bus.o_slv_data), 32'h77);
      bus.i_slv_busy = 1'b0;
      repeat (17) tick();

      // rd_done on the timeout cycle, plus an RX byte during the hold.
      post(1, 8'h66);
      tick(); tick();
      e = cyc;
      repeat (3) tick();
      bus.i_slv_wr_done = 1'b1;
      bus.i_slv_data = 8'h3C;
      rx_q.push_back('{data: 8'h3C, cyc: cyc + 1});
      tick();
      bus.i_slv_wr_done = 1'b0;
      repeat (12) tick();
      check_eq("simul_at_cycle", cyc, e + 16);
      read_byte(1);
      check_eq("rx_data_hold", 32'(bus.o_rx_data), 32'h3C);
      tick();

      // Reset mid-hold drops the byte silently; the next request proceeds.
      post(0, 8'h99);
      tick(); tick();
      tick();
      rst = 1'b1;
      tick();
      check_reset_vals("midhold_reset");
      rst = 1'b0;
      repeat (20) tick();
      post(2, 8'h42);
      tick(); tick();
      read_byte(2);
      repeat (2) tick();

      check_eq("sb_grants_left", grant_q.size(), 0);
      check_eq("sb_cmpl_left", cmpl_q.size(), 0);
      check_eq("sb_rx_left", rx_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
